// File: rtl/temporal_ngram_encoder.sv
// rtl/temporal_ngram_encoder.sv - temporal N-gram binding of spatial hypervectors
// Binds each accepted vector with its NGRAM_SIZE-1 predecessors via rotate-and-XOR.
module temporal_ngram_encoder #(
    parameter int HV_DIMENSION = 2000,
    parameter int NGRAM_SIZE   = 4
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RBI,
    input  logic                    Clear_SI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO,
    output logic                    WindowFull_SO
);

    localparam logic [2:0] CNT_MAX = 3'(NGRAM_SIZE - 1);
    localparam logic [2:0] CNT_CLR = (NGRAM_SIZE > 1) ? 3'd1 : 3'd0;

    // Rotation by n toward higher index: index 0 is the packed MSB, so this is a right rotate.
    function automatic logic [0:HV_DIMENSION-1] rho_n(input logic [0:HV_DIMENSION-1] x,
                                                      input int n);
        logic [2*HV_DIMENSION-1:0] d;
        d = {x, x} >> n;
        return d[HV_DIMENSION-1:0];
    endfunction

    logic [2:0]              r_cnt;
    logic                    r_valid;
    logic [0:HV_DIMENSION-1] r_out;
    logic [2:0]              w_cnt_next;
    logic                    w_valid_next;
    logic                    w_produce;
    logic                    w_accept;
    logic                    w_fire;
    logic                    w_full;
    logic [0:HV_DIMENSION-1] w_ngram;

    assign w_full            = (r_cnt == CNT_MAX);
    assign ReadyOut_SO       = !r_valid || ReadyIn_SI;
    assign w_accept          = ValidIn_SI && ReadyOut_SO;
    assign w_fire            = r_valid && ReadyIn_SI;
    assign ValidOut_SO       = r_valid;
    assign HypervectorOut_DO = r_out;
    assign WindowFull_SO     = w_full;

    always_comb begin
        w_cnt_next   = r_cnt;
        w_valid_next = r_valid;
        w_produce    = 1'b0;
        if (w_fire) begin
            w_valid_next = 1'b0;
        end
        // A vector accepted together with a clear only seeds the new window.
        if (Clear_SI) begin
            w_cnt_next = w_accept ? CNT_CLR : 3'd0;
        end else if (w_accept) begin
            if (w_full) begin
                w_produce    = 1'b1;
                w_valid_next = 1'b1;
            end else begin
                w_cnt_next = r_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            r_cnt   <= 3'd0;
            r_valid <= 1'b0;
            r_out   <= '0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_valid <= w_valid_next;
            if (w_produce) begin
                r_out <= w_ngram;
            end
        end
    end

    generate
        if (NGRAM_SIZE > 1) begin : g_hist
            logic [0:HV_DIMENSION-1] r_hist [0:NGRAM_SIZE-2];

            always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
                if (!Reset_RBI) begin
                    for (int k = 0; k < NGRAM_SIZE - 1; k++) begin
                        r_hist[k] <= '0;
                    end
                end else if (Clear_SI) begin
                    for (int k = 0; k < NGRAM_SIZE - 1; k++) begin
                        r_hist[k] <= '0;
                    end
                    if (w_accept) begin
                        r_hist[0] <= HypervectorIn_DI;
                    end
                end else if (w_accept) begin
                    r_hist[0] <= HypervectorIn_DI;
                    for (int k = 1; k < NGRAM_SIZE - 1; k++) begin
                        r_hist[k] <= r_hist[k-1];
                    end
                end
            end

            always_comb begin
                w_ngram = HypervectorIn_DI;
                for (int k = 0; k < NGRAM_SIZE - 1; k++) begin
                    w_ngram = w_ngram ^ rho_n(r_hist[k], k + 1);
                end
            end
        end else begin : g_nohist
            assign w_ngram = HypervectorIn_DI;
        end
    endgenerate

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// tb/tb_temporal_ngram_encoder.sv - bench for temporal_ngram_encoder (N=3 table, N=1 random)
module tb_temporal_ngram_encoder;

    logic       clk;
    logic       rst_n;
    logic       clr, vin, rdy;
    logic [0:7] din;
    logic       ready_o, valid_o, full_o;
    logic [0:7] out_o;

    logic       clr1, vin1, rdy1;
    logic [0:7] din1;
    logic       ready1_o, valid1_o, full1_o;
    logic [0:7] out1_o;

    int n_chk  = 0;
    int n_fail = 0;

    temporal_ngram_encoder #(.HV_DIMENSION(8), .NGRAM_SIZE(3)) dut3 (
        .Clk_CI(clk), .Reset_RBI(rst_n), .Clear_SI(clr), .ValidIn_SI(vin),
        .ReadyOut_SO(ready_o), .HypervectorIn_DI(din), .ValidOut_SO(valid_o),
        .ReadyIn_SI(rdy), .HypervectorOut_DO(out_o), .WindowFull_SO(full_o)
    );

    temporal_ngram_encoder #(.HV_DIMENSION(8), .NGRAM_SIZE(1)) dut1 (
        .Clk_CI(clk), .Reset_RBI(rst_n), .Clear_SI(clr1), .ValidIn_SI(vin1),
        .ReadyOut_SO(ready1_o), .HypervectorIn_DI(din1), .ValidOut_SO(valid1_o),
        .ReadyIn_SI(rdy1), .HypervectorOut_DO(out1_o), .WindowFull_SO(full1_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       clr;
        logic       vin;
        logic       rdy;
        logic [0:7] din;
        logic       e_ready;
        logic       e_valid;
        logic       e_full;
        logic [0:7] e_out;
    } vec_t;

    vec_t tbl [0:17];

    function automatic vec_t mk(input logic c, v, r, input logic [0:7] d,
                                input logic er, ev, ef, input logic [0:7] eo);
        vec_t t;
        t.clr = c; t.vin = v; t.rdy = r; t.din = d;
        t.e_ready = er; t.e_valid = ev; t.e_full = ef; t.e_out = eo;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    logic       m_valid;
    logic [0:7] m_out;
    logic       m_acc;

    initial begin
        rst_n = 1'b0;
        clr = 0; vin = 0; rdy = 1; din = '0;
        clr1 = 0; vin1 = 0; rdy1 = 1; din1 = '0;

        tbl[0]  = mk(0, 0, 1, 8'b00000000, 1, 0, 0, 8'b00000000);
        tbl[1]  = mk(0, 1, 1, 8'b10000000, 1, 0, 0, 8'b00000000);
        tbl[2]  = mk(0, 1, 1, 8'b01000000, 1, 0, 1, 8'b00000000);
        tbl[3]  = mk(0, 1, 1, 8'b00100000, 1, 1, 1, 8'b00100000);
        tbl[4]  = mk(0, 1, 1, 8'b00000001, 1, 1, 1, 8'b00000001);
        for (int i = 5; i <= 9; i++)
            tbl[i] = mk(0, 1, 0, 8'b11000000, 0, 1, 1, 8'b00000001);
        tbl[10] = mk(0, 1, 1, 8'b11000000, 1, 1, 1, 8'b01001000);
        tbl[11] = mk(0, 0, 1, 8'b00000000, 1, 0, 1, 8'b01001000);
        tbl[12] = mk(0, 1, 0, 8'b00110000, 1, 1, 1, 8'b00010000);
        tbl[13] = mk(1, 1, 0, 8'b00000011, 0, 1, 0, 8'b00010000);
        tbl[14] = mk(1, 1, 1, 8'b00000011, 1, 0, 0, 8'b00010000);
        tbl[15] = mk(0, 1, 1, 8'b10000001, 1, 0, 1, 8'b00010000);
        tbl[16] = mk(0, 1, 1, 8'b00000100, 1, 1, 1, 8'b00000100);
        tbl[17] = mk(0, 1, 1, 8'b11111111, 1, 1, 1, 8'b10011101);

        repeat (2) @(negedge clk);
        chk("reset_ready", {7'd0, ready_o}, 8'd1);
        chk("reset_valid", {7'd0, valid_o}, 8'd0);
        chk("reset_out",   out_o,           8'd0);
        chk("reset_full",  {7'd0, full_o},  8'd0);
        rst_n = 1'b1;

        for (int i = 0; i <= 17; i++) begin
            @(negedge clk);
            clr = tbl[i].clr; vin = tbl[i].vin; rdy = tbl[i].rdy; din = tbl[i].din;
            #1;
            chk($sformatf("row%0d_ready", i), {7'd0, ready_o}, {7'd0, tbl[i].e_ready});
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid", i), {7'd0, valid_o}, {7'd0, tbl[i].e_valid});
            chk($sformatf("row%0d_out", i),   out_o,           tbl[i].e_out);
            chk($sformatf("row%0d_full", i),  {7'd0, full_o},  {7'd0, tbl[i].e_full});
        end

        @(negedge clk);
        clr = 0; vin = 0; rdy = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {7'd0, valid_o}, 8'd0);
        chk("async_out",   out_o,           8'd0);
        chk("async_full",  {7'd0, full_o},  8'd0);
        chk("async_ready", {7'd0, ready_o}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;

        m_valid = 1'b0;
        m_out   = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            vin1 = 1'($urandom_range(0, 1));
            rdy1 = 1'($urandom_range(0, 1));
            din1 = 8'($urandom);
            #1;
            chk($sformatf("n1_ready%0d", i), {7'd0, ready1_o}, {7'd0, (!m_valid || rdy1)});
            m_acc = vin1 && (!m_valid || rdy1);
            @(posedge clk);
            #1;
            if (m_acc) begin
                m_valid = 1'b1;
                m_out   = din1;
            end else if (m_valid && rdy1) begin
                m_valid = 1'b0;
            end
            chk($sformatf("n1_valid%0d", i), {7'd0, valid1_o}, {7'd0, m_valid});
            chk($sformatf("n1_out%0d", i),   out1_o,           m_out);
            chk($sformatf("n1_full%0d", i),  {7'd0, full1_o},  8'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
